// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 scan controller:
//             decoder state encoding, key event record, prefix byte values
//             and the odd-parity helper used by the framer.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Prefix-folding decoder states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } dec_state_t;

  // Key event as delivered to the host
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // True when the eight data bits plus the parity bit contain an odd count of ones
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_event_fifo
//  Purpose  : Synchronous first-word fall-through FIFO for key events.
//             The head entry is always visible; a push into a full FIFO is
//             accepted only when a pop happens in the same cycle, otherwise
//             the event is dropped and overflow pulses for one cycle.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, push_data - write request and event
//             ready           - consumer accepts the head entry
//             valid           - FIFO not empty
//             head            - head entry (zero while empty)
//             overflow        - one-cycle pulse per dropped event
//  Revision : 1.0  initial release
// ============================================================================
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       ready,
  output logic       valid,
  output ps2_event_t head,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_event_t    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          overflow_r;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign valid    = !empty;
  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign overflow = overflow_r;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_ctrl
//  Purpose  : PS/2 keyboard receive controller. Synchronizes kbdclk/kbddata,
//             frames 11-bit characters with start/stop (and optional parity)
//             checks and a stall watchdog, folds E0/F0 prefixes into single
//             key events and queues them in an FWFT FIFO.
//  Build    : define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity;
//             otherwise the parity bit is sampled and ignored.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             kbdclk, kbddata     - raw asynchronous PS/2 lines
//             ev_valid, ev_ready  - event handshake
//             ev_code/ext/brk     - head event fields
//             frame_err           - pulse on framing/parity/timeout error
//             overflow            - pulse when an event is dropped (FIFO full)
//             busy                - frame in progress
//  Revision : 1.0  initial release
// ============================================================================
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbdclk,
  input  logic       kbddata,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // --------------------------------------------------------------------------
  // Synchronizers and falling-edge strobe
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   din;

  // Reset to the idle-high line level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbdclk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], kbddata};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign din  = data_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Framer and watchdog
  // --------------------------------------------------------------------------
  logic [3:0]      bitn;
  logic [7:0]      shreg;
  logic [7:0]      byte_val;
  logic            byte_done;
  logic            frame_err_r;
  logic [WD_W-1:0] wd;
`ifdef PS2_PARITY_CHECK_EN
  logic            par_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bitn        <= 4'd0;
      shreg       <= 8'h00;
      byte_val    <= 8'h00;
      byte_done   <= 1'b0;
      frame_err_r <= 1'b0;
      wd          <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      byte_done   <= 1'b0;
      frame_err_r <= 1'b0;
      if (fall) begin
        wd <= '0;
        case (bitn)
          4'd0: begin
            // A high start bit is rejected without leaving the idle position
            if (din) frame_err_r <= 1'b1;
            else     bitn        <= 4'd1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shreg <= {din, shreg[7:1]};
            bitn  <= bitn + 4'd1;
          end
          4'd9: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= din;
`endif
            bitn    <= 4'd10;
          end
          default: begin
            bitn <= 4'd0;
            if (!din) begin
              frame_err_r <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            end else if (!ps2_parity_ok(shreg, par_bit)) begin
              frame_err_r <= 1'b1;
`endif
            end else begin
              byte_done <= 1'b1;
              byte_val  <= shreg;
            end
          end
        endcase
      end else if (bitn != 4'd0) begin
        if (wd == WD_W'(TIMEOUT_CYCLES)) begin
          bitn        <= 4'd0;
          wd          <= '0;
          frame_err_r <= 1'b1;
        end else begin
          wd <= wd + 1'b1;
        end
      end else begin
        wd <= '0;
      end
    end
  end

  assign busy      = (bitn != 4'd0);
  assign frame_err = frame_err_r;

  // --------------------------------------------------------------------------
  // Prefix-folding decoder
  // --------------------------------------------------------------------------
  dec_state_t state;
  dec_state_t state_next;
  logic       push_req;
  ps2_event_t push_ev_next;
  logic       push_vld;
  ps2_event_t push_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      push_vld <= 1'b0;
      push_ev  <= '0;
    end else begin
      state    <= state_next;
      push_vld <= push_req;
      push_ev  <= push_ev_next;
    end
  end

  always_comb begin
    state_next        = state;
    push_req          = 1'b0;
    push_ev_next.ext  = (state == ST_EXT) || (state == ST_EXTBRK);
    push_ev_next.brk  = (state == ST_BRK) || (state == ST_EXTBRK);
    push_ev_next.code = byte_val;
    if (frame_err_r) begin
      // Any error abandons whatever prefixes were pending
      state_next = ST_IDLE;
    end else if (byte_done) begin
      if (byte_val == PS2_PFX_EXT) begin
        state_next = push_ev_next.brk ? ST_EXTBRK : ST_EXT;
      end else if (byte_val == PS2_PFX_BRK) begin
        state_next = push_ev_next.ext ? ST_EXTBRK : ST_BRK;
      end else begin
        push_req   = 1'b1;
        state_next = ST_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  ps2_event_t head;

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_vld),
    .push_data (push_ev),
    .ready     (ev_ready),
    .valid     (ev_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign ev_code = head.code;
  assign ev_ext  = head.ext;
  assign ev_brk  = head.brk;

endmodule
`default_nettype wire
